// File: rtl/param_sync_fifo.sv
// Single-clock FIFO with occupancy counter, threshold flags, sticky errors
// and a choice of registered or first-word-fall-through read data.
module param_sync_fifo #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
  parameter int FWFT     = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       wr_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       rd_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       almost_full_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] FULL_L = CW'(DEPTH);
  localparam logic [CW-1:0] AF_L   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_L   = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             ovf_q;
  logic             udf_q;
  logic             rd_acc;
  logic             wr_acc;

  assign empty_o        = (count == '0);
  assign full_o         = (count == FULL_L);
  assign almost_full_o  = (count >= AF_L);
  assign almost_empty_o = (count <= AE_L);
  assign count_o        = count;
  assign overflow_o     = ovf_q;
  assign underflow_o    = udf_q;

  // A pop frees a slot in the same cycle, so a full FIFO may still write.
  assign rd_acc = rd_i & ~empty_o & ~rst_i;
  assign wr_acc = wr_i & (~full_o | rd_acc) & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else if (clr_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
    end else begin
      if (wr_acc)
        wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc)
        rd_ptr <= rd_ptr + 1'b1;
      unique case (1'b1)
        (wr_acc & ~rd_acc): count <= count + 1'b1;
        (rd_acc & ~wr_acc): count <= count - 1'b1;
        default:            count <= count;
      endcase
      if (wr_i & ~wr_acc)
        ovf_q <= 1'b1;
      if (rd_i & empty_o)
        udf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_acc & ~clr_i)
      mem[wr_ptr] <= din_i;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign dout_o = mem[rd_ptr];
    end else begin : g_reg
      logic [WIDTH-1:0] dout_q;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
          dout_q <= '0;
        else if (rd_acc & ~clr_i)
          dout_q <= mem[rd_ptr];
      end

      assign dout_o = dout_q;
    end
  endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench: registered-read instance (a) and FWFT instance (b)
// sharing clock and reset, hand-computed expectations.
module tb_param_sync_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        clr_a = 0, wr_a = 0, rd_a = 0;
  logic [15:0] din_a = '0, dout_a;
  logic        full_a, empty_a, af_a, ae_a, ovf_a, udf_a;
  logic [3:0]  cnt_a;

  logic        clr_b = 0, wr_b = 0, rd_b = 0;
  logic [15:0] din_b = '0, dout_b;
  logic        full_b, empty_b, af_b, ae_b, ovf_b, udf_b;
  logic [3:0]  cnt_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  param_sync_fifo #(.WIDTH(16), .DEPTH(8), .FWFT(0)) u_a (
    .clk_i(clk), .rst_i(rst), .clr_i(clr_a),
    .wr_i(wr_a), .din_i(din_a), .rd_i(rd_a),
    .dout_o(dout_a), .full_o(full_a), .empty_o(empty_a),
    .almost_full_o(af_a), .almost_empty_o(ae_a),
    .count_o(cnt_a), .overflow_o(ovf_a), .underflow_o(udf_a)
  );

  param_sync_fifo #(.WIDTH(16), .DEPTH(8), .FWFT(1)) u_b (
    .clk_i(clk), .rst_i(rst), .clr_i(clr_b),
    .wr_i(wr_b), .din_i(din_b), .rd_i(rd_b),
    .dout_o(dout_b), .full_o(full_b), .empty_o(empty_b),
    .almost_full_o(af_b), .almost_empty_o(ae_b),
    .count_o(cnt_b), .overflow_o(ovf_b), .underflow_o(udf_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("rst_cnt", 32'(cnt_a), 0);
    check("rst_empty", 32'(empty_a), 1);
    check("rst_ae", 32'(ae_a), 1);
    check("rst_full", 32'(full_a), 0);
    check("rst_af", 32'(af_a), 0);
    check("rst_dout", 32'(dout_a), 0);
    check("rst_ovf", 32'(ovf_a), 0);
    check("rst_udf", 32'(udf_a), 0);
    step();
    rst = 1'b0;
    step();

    // fill 0x1111..0x8888
    for (int i = 0; i < 8; i++) begin
      wr_a = 1; din_a = 16'((i + 1) * 16'h1111);
      step();
      if (i == 1) check("ae_off", 32'(ae_a), 0);
      if (i == 6) begin
        check("cnt7", 32'(cnt_a), 7);
        check("af7", 32'(af_a), 1);
        check("full7", 32'(full_a), 0);
      end
    end
    wr_a = 0;
    check("cnt8", 32'(cnt_a), 8);
    check("full8", 32'(full_a), 1);
    check("ovf_pre", 32'(ovf_a), 0);
    wr_a = 1; din_a = 16'h9999;
    step();
    wr_a = 0;
    check("ovf_set", 32'(ovf_a), 1);
    check("ovf_cnt", 32'(cnt_a), 8);

    // drain, registered read
    for (int i = 0; i < 8; i++) begin
      rd_a = 1;
      step();
      check($sformatf("drain%0d", i), 32'(dout_a), (i + 1) * 32'h1111);
    end
    rd_a = 0;
    check("dry_empty", 32'(empty_a), 1);
    check("udf_pre", 32'(udf_a), 0);
    rd_a = 1;
    step();
    rd_a = 0;
    check("udf_set", 32'(udf_a), 1);
    check("dout_hold", 32'(dout_a), 32'h8888);

    clr_a = 1;
    step();
    clr_a = 0;
    check("clr_ovf", 32'(ovf_a), 0);
    check("clr_udf", 32'(udf_a), 0);

    // full with simultaneous push/pop, then wrap
    for (int i = 0; i < 8; i++) begin
      wr_a = 1; din_a = 16'((i + 1) * 16'h1111);
      step();
    end
    for (int j = 0; j < 3; j++) begin
      wr_a = 1; rd_a = 1; din_a = 16'(16'hA001 + j);
      step();
      check($sformatf("wr_rd_dout%0d", j), 32'(dout_a), (j + 1) * 32'h1111);
      check($sformatf("wr_rd_cnt%0d", j), 32'(cnt_a), 8);
    end
    wr_a = 0; rd_a = 0;
    check("wr_rd_ovf", 32'(ovf_a), 0);
    for (int i = 0; i < 8; i++) begin
      rd_a = 1;
      step();
      check($sformatf("wrap%0d", i), 32'(dout_a),
            (i < 5) ? (i + 4) * 32'h1111 : 32'hA001 + 32'(i - 5));
    end
    rd_a = 0;

    // empty with simultaneous push/pop
    wr_a = 1; rd_a = 1; din_a = 16'h5A5A;
    step();
    wr_a = 0; rd_a = 0;
    check("er_cnt", 32'(cnt_a), 1);
    check("er_udf", 32'(udf_a), 1);
    check("er_dout", 32'(dout_a), 32'hA003);
    clr_a = 1;
    step();
    clr_a = 0;
    check("clr_cnt", 32'(cnt_a), 0);
    check("clr_empty", 32'(empty_a), 1);
    check("clr_udf2", 32'(udf_a), 0);

    // FWFT instance
    wr_b = 1; din_b = 16'hABCD;
    step();
    wr_b = 0;
    check("fw_dout", 32'(dout_b), 32'hABCD);
    check("fw_nempty", 32'(empty_b), 0);
    rd_b = 1;
    step();
    rd_b = 0;
    check("fw_empty", 32'(empty_b), 1);
    check("fw_cnt", 32'(cnt_b), 0);
    wr_b = 1; din_b = 16'h1234;
    step();
    din_b = 16'h5678;
    step();
    wr_b = 0;
    check("fw_head1", 32'(dout_b), 32'h1234);
    rd_b = 1;
    step();
    rd_b = 0;
    check("fw_head2", 32'(dout_b), 32'h5678);
    check("fw_cnt1", 32'(cnt_b), 1);

    // async reset mid-operation
    for (int i = 0; i < 4; i++) begin
      wr_a = 1; din_a = 16'(16'h0100 + i);
      step();
    end
    wr_a = 0;
    rd_a = 1;
    step();
    rd_a = 0;
    check("pre_rst_dout", 32'(dout_a), 32'h0100);
    #2 rst = 1;
    #1;
    check("arst_cnt", 32'(cnt_a), 0);
    check("arst_empty", 32'(empty_a), 1);
    check("arst_dout", 32'(dout_a), 0);
    check("arst_b_cnt", 32'(cnt_b), 0);
    step();
    rst = 0;
    rd_a = 1;
    step();
    rd_a = 0;
    check("post_udf", 32'(udf_a), 1);
    check("post_cnt", 32'(cnt_a), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 The block SHALL have parameter DEPTH, default 8, entry count, power of two, >=2.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-1, almost-full threshold (1..DEPTH).
REQ-004 The block SHALL have parameter AE_LEVEL, default 1, almost-empty threshold (0..DEPTH-1).
REQ-005 The block SHALL have parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 The block SHALL have port clk_i, input, 1 bit, single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit, reset; asynchronous assertion, active-high.
REQ-008 The block SHALL have port clr_i, input, 1 bit, synchronous flush.
REQ-009 The block SHALL have port wr_i, input, 1 bit, write request.
REQ-010 The block SHALL have port din_i, input, WIDTH bits, write data.
REQ-011 The block SHALL have port rd_i, input, 1 bit, read/pop request.
REQ-012 The block SHALL have port dout_o, output, WIDTH bits, read data.
REQ-013 The block SHALL have ports full_o, empty_o, almost_full_o and almost_empty_o, each output, 1 bit, status flags.
REQ-014 The block SHALL have port count_o, output, $clog2(DEPTH)+1 bits, current occupancy 0..DEPTH.
REQ-015 The block SHALL have ports overflow_o and underflow_o, each output, 1 bit, sticky error flags.

Function
REQ-016 Storage SHALL be DEPTH x WIDTH, addressed by wrapping read/write pointers of $clog2(DEPTH) bits plus a separate occupancy counter.
REQ-017 Write accept SHALL be wr_i & (!full_o | rd_accept); accepted write stores din_i at write pointer, pointer increments modulo DEPTH.
REQ-018 Read accept (rd_accept) SHALL be rd_i & !empty_o; accepted read increments read pointer modulo DEPTH.
REQ-019 count_o SHALL be +1 on write-only accept, -1 on read-only accept, unchanged on both or neither, and never exceed DEPTH or drop below 0.
REQ-020 Flags SHALL be combinational from count_o: empty_o = (count==0), full_o = (count==DEPTH), almost_full_o = (count>=AF_LEVEL), almost_empty_o = (count<=AE_LEVEL).
REQ-021 With FWFT=0, dout_o SHALL load the head entry on the edge that accepts a read (1-cycle latency) and hold otherwise.
REQ-022 With FWFT=1, dout_o SHALL continuously present the head entry (0-cycle latency) while !empty_o; its value when empty_o is don't-care; rd_i pops.
REQ-023 Simultaneous wr_i and rd_i when full SHALL accept both; the read returns the old head, count stays DEPTH.
REQ-024 Simultaneous wr_i and rd_i when empty SHALL accept the write only and set underflow_o.
REQ-025 overflow_o SHALL set on any cycle with wr_i high and write not accepted; underflow_o SHALL set on any cycle with rd_i high and empty_o high; both hold until clr_i or rst_i.
REQ-026 clr_i SHALL take priority over wr_i/rd_i: pointers, count and sticky flags go to 0 on the next edge; memory and dout_o are unchanged.

Reset
REQ-027 rst_i high SHALL immediately force pointers, count_o, overflow_o, underflow_o, and dout_o (FWFT=0) to 0; empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0.
REQ-028 Reset asserted mid-operation SHALL discard all stored entries; no write or read SHALL be accepted while rst_i is high.
REQ-029 Memory contents SHALL NOT require reset.

Verification (WIDTH=16, DEPTH=8, defaults unless stated)
REQ-030 Write 0x1111..0x8888 with one write per cycle -> count_o reaches 8, full_o=1, almost_full_o=1 after the 7th write; a 9th write sets overflow_o and count_o stays 8.
REQ-031 Read the full FIFO dry, FWFT=0 -> dout_o shows 0x1111..0x8888 in order, each one cycle after rd_i; then empty_o=1; an extra rd_i sets underflow_o.
REQ-032 FWFT=1, write 0xABCD into the empty FIFO -> dout_o=0xABCD the cycle after the write edge with rd_i low; rd_i pops it and empty_o=1.
REQ-033 Full FIFO with wr_i=rd_i=1 for 3 cycles -> count_o stays 8, no overflow_o; later reads return the original 5 remaining entries followed by the 3 new words, confirming pointer wrap.
REQ-034 Empty FIFO with wr_i=rd_i=1 -> count_o=1, underflow_o=1; then clr_i -> count_o=0, empty_o=1, underflow_o=0.
REQ-035 Load 4 entries, assert rst_i asynchronously between edges -> count_o=0, empty_o=1, dout_o=0 immediately; a read after release sets underflow_o.
